// File: rtl/controle_envase.sv
// controle_envase: sequencing controller for one bottling station.
// It moves each bottle along the conveyor, fills it, then corks it.
// Each corked bottle consumes one cork from the line stock block,
// signalled by a one-cycle done pulse.
// A fill that never reaches level parks the station in a fault state
// until it is acknowledged.
// An empty cork line holds the bottle at the corking position until
// corks arrive.
module controle_envase #(
    parameter logic [7:0] FILL_TIMEOUT = 8'd50,
    parameter logic [3:0] CORK_TIME    = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       limpa_erro,
    input  logic       sensor_garrafa,
    input  logic       sensor_cheio,
    input  logic       sensor_rolha_pos,
    input  logic [7:0] contagem_rolhas_linha,
    input  logic       alerta_estoque_baixo,
    output logic       motor,
    output logic       valvula,
    output logic       vedador,
    output logic       done,
    output logic       erro,
    output logic       aviso_rolha,
    output logic [2:0] estado,
    output logic [7:0] garrafas_ok
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TRANSPORTE    = 3'd1,
        ENCHENDO      = 3'd2,
        TRANSP_VEDA   = 3'd3,
        AGUARDA_ROLHA = 3'd4,
        VEDANDO       = 3'd5,
        ERRO          = 3'd6
    } state_t;

    // The last timer value allowed in each timed state.
    // Both parameters are zero-extended to the 8-bit timer width.
    localparam logic [7:0] FILL_LAST = FILL_TIMEOUT - 8'd1;
    localparam logic [7:0] CORK_LAST = {4'd0, CORK_TIME} - 8'd1;

    state_t     state;
    state_t     state_n;
    logic [7:0] timer;
    logic [7:0] timer_n;
    logic [7:0] count_n;
    logic       corks_available;

    assign corks_available = (contagem_rolhas_linha != 8'd0);

    // Next-state, timer and bottle-count decisions.
    // The timer only runs inside ENCHENDO and VEDANDO.
    // Every other state holds the timer at zero, so entering a timed state
    // always starts the count from zero.
    always_comb begin
        state_n = state;
        timer_n = 8'd0;
        count_n = garrafas_ok;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = TRANSPORTE;
                end
            end
            TRANSPORTE: begin
                if (!start) begin
                    state_n = IDLE;
                end else if (sensor_garrafa) begin
                    state_n = ENCHENDO;
                end
            end
            ENCHENDO: begin
                if (sensor_cheio) begin
                    state_n = TRANSP_VEDA;
                end else if (timer == FILL_LAST) begin
                    state_n = ERRO;
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            TRANSP_VEDA: begin
                if (sensor_rolha_pos) begin
                    state_n = corks_available ? VEDANDO : AGUARDA_ROLHA;
                end
            end
            AGUARDA_ROLHA: begin
                if (corks_available) begin
                    state_n = VEDANDO;
                end
            end
            VEDANDO: begin
                if (timer == CORK_LAST) begin
                    state_n = start ? TRANSPORTE : IDLE;
                    if (garrafas_ok != 8'hFF) begin
                        count_n = garrafas_ok + 8'd1;
                    end
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            ERRO: begin
                if (limpa_erro) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, timer and counter registers.
    // The actuator outputs are decoded from the next state here, so each
    // output is registered yet lines up with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= 8'd0;
            garrafas_ok <= 8'd0;
            motor       <= 1'b0;
            valvula     <= 1'b0;
            vedador     <= 1'b0;
            done        <= 1'b0;
            erro        <= 1'b0;
            aviso_rolha <= 1'b0;
            estado      <= 3'd0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            garrafas_ok <= count_n;
            motor       <= (state_n == TRANSPORTE) || (state_n == TRANSP_VEDA);
            valvula     <= (state_n == ENCHENDO);
            vedador     <= (state_n == VEDANDO);
            done        <= (state_n == VEDANDO) && (timer_n == CORK_LAST);
            erro        <= (state_n == ERRO);
            aviso_rolha <= (state_n == AGUARDA_ROLHA) || alerta_estoque_baixo;
            estado      <= state_n;
        end
    end

endmodule

// File: tb/tb_controle_envase.sv
// Testbench for controle_envase.
// It combines a directed vector table, hand-written corner sequences and
// random stimulus checked against a cycle-level behavioural model.
module tb_controle_envase;

    localparam int FILL = 50;
    localparam int CORK = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       limpa_erro;
    logic       sensor_garrafa;
    logic       sensor_cheio;
    logic       sensor_rolha_pos;
    logic [7:0] contagem_rolhas_linha;
    logic       alerta_estoque_baixo;
    logic       motor;
    logic       valvula;
    logic       vedador;
    logic       done;
    logic       erro;
    logic       aviso_rolha;
    logic [2:0] estado;
    logic [7:0] garrafas_ok;

    int errors = 0;
    int checks = 0;

    // Model state: station phase code, phase timer, bottle tally and the
    // alert level seen at the last edge.
    int mState = 0;
    int mTimer = 0;
    int mCount = 0;
    int mAlert = 0;

    typedef struct {
        logic       st;
        logic       le;
        logic       sg;
        logic       sc;
        logic       srp;
        logic [7:0] cnt;
        logic       al;
        int         reps;
        logic [2:0] eEstado;
        logic       eMotor;
        logic       eValv;
        logic       eVed;
        logic       eDone;
        logic       eErro;
        logic       eAviso;
        logic [7:0] eOk;
    } vec_t;

    vec_t vecs[$];

    controle_envase dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .limpa_erro            (limpa_erro),
        .sensor_garrafa        (sensor_garrafa),
        .sensor_cheio          (sensor_cheio),
        .sensor_rolha_pos      (sensor_rolha_pos),
        .contagem_rolhas_linha (contagem_rolhas_linha),
        .alerta_estoque_baixo  (alerta_estoque_baixo),
        .motor                 (motor),
        .valvula               (valvula),
        .vedador               (vedador),
        .done                  (done),
        .erro                  (erro),
        .aviso_rolha           (aviso_rolha),
        .estado                (estado),
        .garrafas_ok           (garrafas_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic st, le, sg, sc, srp, input logic [7:0] cnt,
                                input logic al, input int reps, input logic [2:0] e,
                                input logic m, v, ved, d, er, av, input logic [7:0] ok);
        vec_t r;
        r.st = st; r.le = le; r.sg = sg; r.sc = sc; r.srp = srp; r.cnt = cnt; r.al = al;
        r.reps = reps; r.eEstado = e; r.eMotor = m; r.eValv = v; r.eVed = ved;
        r.eDone = d; r.eErro = er; r.eAviso = av; r.eOk = ok;
        return r;
    endfunction

    // One edge of the station, in terms of bottle handling.
    task automatic modelStep(input logic st, le, sg, sc, srp, input logic [7:0] cnt, input logic al);
        int ns;
        int nt;
        ns = mState;
        nt = 0;
        case (mState)
            0: if (st) ns = 1;
            1: if (!st) ns = 0; else if (sg) ns = 2;
            2: begin
                if (sc) ns = 3;
                else if (mTimer == FILL - 1) ns = 6;
                else nt = mTimer + 1;
            end
            3: if (srp) ns = (cnt != 0) ? 5 : 4;
            4: if (cnt != 0) ns = 5;
            5: begin
                if (mTimer == CORK - 1) begin
                    ns = st ? 1 : 0;
                    if (mCount < 255) mCount = mCount + 1;
                end else begin
                    nt = mTimer + 1;
                end
            end
            6: if (le) ns = 0;
            default: ns = 0;
        endcase
        mState = ns;
        mTimer = nt;
        mAlert = al ? 1 : 0;
    endtask

    task automatic modelReset();
        mState = 0;
        mTimer = 0;
        mCount = 0;
        mAlert = 0;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eEstado,
                               input logic eM, eV, eVed, eD, eE, eAv, input logic [7:0] eOk);
        logic [16:0] got;
        logic [16:0] exp;
        got = {estado, motor, valvula, vedador, done, erro, aviso_rolha, garrafas_ok};
        exp = {eEstado, eM, eV, eVed, eD, eE, eAv, eOk};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got estado=%0d m=%b v=%b ved=%b d=%b e=%b av=%b ok=%0d, expected estado=%0d m=%b v=%b ved=%b d=%b e=%b av=%b ok=%0d",
                     name, estado, motor, valvula, vedador, done, erro, aviso_rolha, garrafas_ok,
                     eEstado, eM, eV, eVed, eD, eE, eAv, eOk);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, 3'(mState), (mState == 1) || (mState == 3), mState == 2, mState == 5,
                    (mState == 5) && (mTimer == CORK - 1), mState == 6,
                    (mState == 4) || (mAlert != 0), 8'(mCount));
    endtask

    // Drives one set of inputs for one clock edge and leaves time at
    // one unit after that edge, ready for sampling.
    task automatic applyStimulus(input logic st, le, sg, sc, srp, input logic [7:0] cnt, input logic al);
        @(negedge clk);
        start = st;
        limpa_erro = le;
        sensor_garrafa = sg;
        sensor_cheio = sc;
        sensor_rolha_pos = srp;
        contagem_rolhas_linha = cnt;
        alerta_estoque_baixo = al;
        modelStep(st, le, sg, sc, srp, cnt, al);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        start = 0; limpa_erro = 0; sensor_garrafa = 0; sensor_cheio = 0;
        sensor_rolha_pos = 0; contagem_rolhas_linha = 0; alerta_estoque_baixo = 0;
        modelReset();
        #1;
        checkOutput("reset", 3'd0, 0, 0, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int doneCnt;
        reset = 1'b1;
        start = 0; limpa_erro = 0; sensor_garrafa = 0; sensor_cheio = 0;
        sensor_rolha_pos = 0; contagem_rolhas_linha = 0; alerta_estoque_baixo = 0;
        #2;

        // Directed vectors: a full bottle, a cork-starved bottle, the
        // alert path and start dropped mid-bottle.
        vecs.push_back(mk(1,0,0,0,0,8'd0,0,1, 3'd1,1,0,0,0,0,0,8'd0));
        vecs.push_back(mk(1,0,1,0,0,8'd0,0,1, 3'd2,0,1,0,0,0,0,8'd0));
        vecs.push_back(mk(1,0,0,0,0,8'd0,0,9, 3'd2,0,1,0,0,0,0,8'd0));
        vecs.push_back(mk(1,0,0,1,0,8'd0,0,1, 3'd3,1,0,0,0,0,0,8'd0));
        vecs.push_back(mk(1,0,0,0,0,8'd5,0,2, 3'd3,1,0,0,0,0,0,8'd0));
        vecs.push_back(mk(1,0,0,0,1,8'd5,0,1, 3'd5,0,0,1,0,0,0,8'd0));
        vecs.push_back(mk(1,0,0,0,0,8'd5,0,1, 3'd5,0,0,1,0,0,0,8'd0));
        vecs.push_back(mk(1,0,0,0,0,8'd5,0,1, 3'd5,0,0,1,1,0,0,8'd0));
        vecs.push_back(mk(1,0,0,0,0,8'd5,0,1, 3'd1,1,0,0,0,0,0,8'd1));
        vecs.push_back(mk(1,0,1,0,0,8'd0,0,1, 3'd2,0,1,0,0,0,0,8'd1));
        vecs.push_back(mk(1,0,0,1,0,8'd0,0,1, 3'd3,1,0,0,0,0,0,8'd1));
        vecs.push_back(mk(1,0,0,0,1,8'd0,0,1, 3'd4,0,0,0,0,0,1,8'd1));
        vecs.push_back(mk(1,0,0,0,1,8'd0,0,3, 3'd4,0,0,0,0,0,1,8'd1));
        vecs.push_back(mk(1,0,0,0,0,8'd4,0,1, 3'd5,0,0,1,0,0,0,8'd1));
        vecs.push_back(mk(1,0,0,0,0,8'd4,0,1, 3'd5,0,0,1,0,0,0,8'd1));
        vecs.push_back(mk(0,0,0,0,0,8'd4,0,1, 3'd5,0,0,1,1,0,0,8'd1));
        vecs.push_back(mk(0,0,0,0,0,8'd4,0,1, 3'd0,0,0,0,0,0,0,8'd2));
        vecs.push_back(mk(0,0,1,0,0,8'd4,1,1, 3'd0,0,0,0,0,0,1,8'd2));
        vecs.push_back(mk(0,0,0,0,0,8'd4,0,1, 3'd0,0,0,0,0,0,0,8'd2));
        vecs.push_back(mk(1,0,0,0,0,8'd0,0,1, 3'd1,1,0,0,0,0,0,8'd2));
        vecs.push_back(mk(1,0,1,0,0,8'd0,0,1, 3'd2,0,1,0,0,0,0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,8'd0,0,3, 3'd2,0,1,0,0,0,0,8'd2));
        vecs.push_back(mk(0,0,0,1,0,8'd0,0,1, 3'd3,1,0,0,0,0,0,8'd2));
        vecs.push_back(mk(0,0,0,0,1,8'd7,0,1, 3'd5,0,0,1,0,0,0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,8'd7,0,1, 3'd5,0,0,1,0,0,0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,8'd7,0,1, 3'd5,0,0,1,1,0,0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,8'd7,0,1, 3'd0,0,0,0,0,0,0,8'd3));

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].st, vecs[i].le, vecs[i].sg, vecs[i].sc, vecs[i].srp,
                              vecs[i].cnt, vecs[i].al);
                checkOutput($sformatf("vec%0d", i), vecs[i].eEstado, vecs[i].eMotor, vecs[i].eValv,
                            vecs[i].eVed, vecs[i].eDone, vecs[i].eErro, vecs[i].eAviso, vecs[i].eOk);
            end
        end

        // Fill timeout: ERRO exactly 50 edges after ENCHENDO entry, start
        // ignored while faulted, acknowledge returns to IDLE.
        doReset();
        applyStimulus(1,0,0,0,0,8'd0,0);
        applyStimulus(1,0,1,0,0,8'd0,0);
        for (int i = 1; i < FILL; i++) applyStimulus(1,0,0,0,0,8'd0,0);
        checkOutput("fill_last", 3'd2, 0, 1, 0, 0, 0, 0, 8'd0);
        applyStimulus(1,0,0,0,0,8'd0,0);
        checkOutput("timeout", 3'd6, 0, 0, 0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1,0,1,0,0,8'd0,0);
        checkOutput("erro_hold", 3'd6, 0, 0, 0, 0, 1, 0, 8'd0);
        applyStimulus(1,1,0,0,0,8'd0,0);
        checkOutput("limpa", 3'd0, 0, 0, 0, 0, 0, 0, 8'd0);

        // Level reached in the same cycle as the timeout: fill wins.
        applyStimulus(1,0,0,0,0,8'd0,0);
        applyStimulus(1,0,1,0,0,8'd0,0);
        for (int i = 1; i < FILL; i++) applyStimulus(1,0,0,0,0,8'd0,0);
        applyStimulus(1,0,0,1,0,8'd0,0);
        checkOutput("cheio_wins", 3'd3, 1, 0, 0, 0, 0, 0, 8'd0);

        // Counter saturation over 260 bottles, one done per bottle.
        doReset();
        doneCnt = 0;
        applyStimulus(1,0,0,0,0,8'd0,0);
        for (int b = 1; b <= 260; b++) begin
            applyStimulus(1,0,1,0,0,8'd5,0);
            applyStimulus(1,0,0,1,0,8'd5,0);
            applyStimulus(1,0,0,0,1,8'd5,0);
            for (int k = 0; k < CORK; k++) begin
                applyStimulus(1,0,0,0,0,8'd5,0);
                if (done) doneCnt++;
            end
            if (b == 254) checkOutput("count254", 3'd1, 1, 0, 0, 0, 0, 0, 8'd254);
        end
        checkOutput("saturate", 3'd1, 1, 0, 0, 0, 0, 0, 8'd255);
        checks++;
        if (doneCnt != 260) begin
            errors++;
            $display("[TB] FAIL done_pulses: got %0d, expected 260", doneCnt);
        end

        // Asynchronous reset in the middle of corking.
        applyStimulus(1,0,1,0,0,8'd5,0);
        applyStimulus(1,0,0,1,0,8'd5,0);
        applyStimulus(1,0,0,0,1,8'd5,0);
        applyStimulus(1,0,0,0,0,8'd5,0);
        checkOutput("pre_reset", 3'd5, 0, 0, 1, 0, 0, 0, 8'd255);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", 3'd0, 0, 0, 0, 0, 0, 0, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 3'd0, 0, 0, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        start = 0; sensor_garrafa = 0; sensor_cheio = 0; sensor_rolha_pos = 0;
        contagem_rolhas_linha = 0;
        reset = 1'b1;

        // Random stimulus against the behavioural model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic st, le, sg, sc, srp, al;
            logic [7:0] cnt;
            st  = ($urandom % 8) != 0;
            le  = ($urandom % 16) == 0;
            sg  = ($urandom % 3) == 0;
            sc  = (i < 1500) ? (($urandom % 4) == 0) : (($urandom % 64) == 0);
            srp = ($urandom % 3) == 0;
            cnt = (($urandom % 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            al  = ($urandom % 6) == 0;
            applyStimulus(st, le, sg, sc, srp, cnt, al);
            checkModel("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_envase.md
Name: controle_envase

Overview:
- Sequencing controller for one bottling station: conveyor transport, fill valve and corking actuator.
- Consumes corks from the line stock: emits a one-cycle `done` pulse per corked bottle, which drives the stock block's `done` input.
- Reads the stock block's line cork count and low-stock alert, and stalls the bottle at the corking position when the line is empty.
- Sits between the plant sensors/actuators and the cork stock block.

Parameters:
- FILL_TIMEOUT, 8'd50: maximum cycles in ENCHENDO without `sensor_cheio` before fault.
- CORK_TIME, 4'd3: cycles `vedador` is held asserted per bottle (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run-enable level.
- limpa_erro  in  1  fault acknowledge; exits ERRO.
- sensor_garrafa  in  1  bottle present at fill position.
- sensor_cheio  in  1  fill level reached.
- sensor_rolha_pos  in  1  bottle present at corking position.
- contagem_rolhas_linha  in  8  corks available on line, from the stock block.
- alerta_estoque_baixo  in  1  low-stock flag, from the stock block.
- motor  out  1  conveyor run.
- valvula  out  1  fill valve open.
- vedador  out  1  corking actuator.
- done  out  1  one-cycle pulse; one cork consumed.
- erro  out  1  fill-timeout fault.
- aviso_rolha  out  1  waiting for corks, or low-stock alert active.
- estado  out  3  current state code.
- garrafas_ok  out  8  completed-bottle count.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; timers 0; `garrafas_ok` 0; all outputs 0. Applies mid-operation; the in-progress bottle is abandoned.
- Outputs are Moore, decoded from the registered state and timer; no input-to-output combinational paths.
- State codes:
  - IDLE=0
  - TRANSPORTE=1
  - ENCHENDO=2
  - TRANSP_VEDA=3
  - AGUARDA_ROLHA=4
  - VEDANDO=5
  - ERRO=6
- IDLE: all actuators 0. start=1 -> TRANSPORTE.
- TRANSPORTE: motor=1.
  - start=0 -> IDLE.
  - Else sensor_garrafa=1 -> ENCHENDO; timer cleared.
- ENCHENDO: valvula=1; timer increments each cycle.
  - sensor_cheio=1 -> TRANSP_VEDA.
  - Else timer==FILL_TIMEOUT-1 -> ERRO.
  - sensor_cheio and timeout in the same cycle: sensor_cheio wins.
- TRANSP_VEDA: motor=1. When sensor_rolha_pos=1:
  - contagem_rolhas_linha != 0 -> VEDANDO, timer cleared.
  - contagem_rolhas_linha == 0 -> AGUARDA_ROLHA.
- AGUARDA_ROLHA: motor=0; aviso_rolha=1. contagem_rolhas_linha != 0 -> VEDANDO, timer cleared.
- VEDANDO: vedador=1 for exactly CORK_TIME cycles.
  - In the final cycle (timer==CORK_TIME-1), done=1 for that single cycle.
  - garrafas_ok increments at the closing edge; saturates at 255, no wrap.
  - Next state: start=1 -> TRANSPORTE, else IDLE.
- ERRO: all actuators 0; erro=1. limpa_erro=1 -> IDLE. start is ignored.
- start is sampled only in IDLE, TRANSPORTE and at VEDANDO exit. Dropping start mid-bottle completes the current bottle first.
- aviso_rolha = (state==AGUARDA_ROLHA) OR alerta_estoque_baixo; this registered OR is the only exception to the Moore decode.
- Exactly one done pulse per bottle. done is never asserted while contagem_rolhas_linha was 0 at VEDANDO entry.
- Timer width is 8 bits, compared against parameters zero-extended.

Test Plan:
- Reset release, start=1, bottle arrives, cheio after 10 cycles, rolha_pos, contagem=5 -> states 1,2,3,5,1; vedador high for 3 cycles; one done pulse; garrafas_ok=1.
- Fill with no sensor_cheio -> ERRO exactly 50 cycles after ENCHENDO entry; erro=1, valvula=0; limpa_erro -> IDLE, erro=0.
- rolha_pos with contagem=0 -> AGUARDA_ROLHA, motor=0, aviso_rolha=1, no done; contagem set to 4 -> VEDANDO next cycle, one done.
- start dropped during ENCHENDO -> bottle completes with done=1, then IDLE, motor=0.
- 260 bottles completed -> garrafas_ok saturates at 255; reset asserted during VEDANDO -> immediate IDLE, vedador=0, no done, count=0.
